// File: rtl/dreg_readback.sv
// Read-side companion to the data register: snapshots a W-bit value on request
// and streams it MSB-first in B-bit chunks over a valid/ready handshake.
module dreg_readback #(
  parameter int W = 16,
  parameter int B = 4
) (
  input  logic         clk50m,
  input  logic         rst_n,
  input  logic         en,
  input  logic         rd_req,
  input  logic [W-1:0] rd_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [B-1:0] out_data,
  output logic         out_last,
  output logic         busy,
  output logic         done
);

  localparam int N  = W / B;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  shadow;
  logic [CW-1:0] cnt;

  // The shadow is shifted left after each accepted chunk, so the current
  // chunk is always its top B bits.
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      shadow <= '0;
      cnt    <= '0;
    end else if (en) begin
      case (state)
        S_IDLE: begin
          if (rd_req) begin
            shadow <= rd_data;
            cnt    <= '0;
            state  <= S_SEND;
          end
        end
        S_SEND: begin
          if (out_ready) begin
            if (cnt == LAST_IDX) begin
              state <= S_DONE;
            end else begin
              shadow <= shadow << B;
              cnt    <= cnt + 1'b1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode from state so reset clears them immediately; out_data is
  // forced to zero outside SEND so stale shadow bits never leak out.
  always_comb begin
    out_valid = (state == S_SEND);
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    out_data  = out_valid ? shadow[W-1 -: B] : '0;
    out_last  = out_valid && (cnt == LAST_IDX);
  end

endmodule

// File: tb/tb_dreg_readback.sv
// Bench for dreg_readback: three parameterisations driven together and checked
// every cycle against a chunk-queue model, plus literal stream checks.
module tb_dreg_readback;

  logic        clk50m = 1'b0;
  logic        rst_n;
  logic        en;
  logic        rd_req;
  logic        out_ready;
  logic [15:0] rd16;
  logic [7:0]  rd8;

  logic       v0, l0, b0, d0;
  logic [3:0] o0;
  logic       v1, l1, b1, d1;
  logic [7:0] o1;
  logic       v2, l2, b2, d2;
  logic [0:0] o2;

  always #5 clk50m = ~clk50m;

  dreg_readback #(.W(16), .B(4)) u0 (
    .clk50m(clk50m), .rst_n(rst_n), .en(en), .rd_req(rd_req), .rd_data(rd16),
    .out_ready(out_ready), .out_valid(v0), .out_data(o0), .out_last(l0),
    .busy(b0), .done(d0));

  dreg_readback #(.W(8), .B(8)) u1 (
    .clk50m(clk50m), .rst_n(rst_n), .en(en), .rd_req(rd_req), .rd_data(rd8),
    .out_ready(out_ready), .out_valid(v1), .out_data(o1), .out_last(l1),
    .busy(b1), .done(d1));

  dreg_readback #(.W(16), .B(1)) u2 (
    .clk50m(clk50m), .rst_n(rst_n), .en(en), .rd_req(rd_req), .rd_data(rd16),
    .out_ready(out_ready), .out_valid(v2), .out_data(o2), .out_last(l2),
    .busy(b2), .done(d2));

  logic       dv[3], dl[3], db[3], dd[3];
  logic [7:0] dq[3];
  assign dv[0] = v0; assign dl[0] = l0; assign db[0] = b0; assign dd[0] = d0;
  assign dv[1] = v1; assign dl[1] = l1; assign db[1] = b1; assign dd[1] = d1;
  assign dv[2] = v2; assign dl[2] = l2; assign db[2] = b2; assign dd[2] = d2;
  assign dq[0] = {4'h0, o0};
  assign dq[1] = o1;
  assign dq[2] = {7'h0, o2};

  int WK[3] = '{16, 8, 16};
  int BK[3] = '{4, 8, 1};

  // Model: a word is a queue of chunks still owed to the sink, followed by
  // a single done cycle once the queue drains.
  int mq[3][$];
  bit mdone[3];

  int acc[3][$];
  int nlast[3], ndone[3], nbusy[3];

  int total = 0;
  int bad = 0;

  function automatic int chunk_of(int k, logic [15:0] word, int i);
    int n;
    logic [15:0] sh;
    n  = WK[k] / BK[k];
    sh = word >> (BK[k] * (n - 1 - i));
    return int'(sh) & ((1 << BK[k]) - 1);
  endfunction

  task automatic check(string nm, int k, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h want=%0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      mq[k].delete();
      mdone[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [15:0] word;
    if (!rst_n) begin
      model_clear();
    end else if (en) begin
      for (int k = 0; k < 3; k++) begin
        word = (k == 1) ? {8'h00, rd8} : rd16;
        if (mdone[k]) begin
          mdone[k] = 1'b0;
        end else if (mq[k].size() > 0) begin
          if (out_ready) begin
            void'(mq[k].pop_front());
            if (mq[k].size() == 0) mdone[k] = 1'b1;
          end
        end else if (rd_req) begin
          for (int i = 0; i < WK[k] / BK[k]; i++) mq[k].push_back(chunk_of(k, word, i));
        end
      end
    end
  endtask

  task automatic compare_all();
    int ev, ed, el;
    for (int k = 0; k < 3; k++) begin
      ev = (mq[k].size() > 0) ? 1 : 0;
      ed = ev ? mq[k][0] : 0;
      el = (mq[k].size() == 1) ? 1 : 0;
      check("valid", k, int'(dv[k]), ev);
      check("data",  k, int'(dq[k]), ed);
      check("last",  k, int'(dl[k]), el);
      check("busy",  k, int'(db[k]), (ev != 0 || mdone[k]) ? 1 : 0);
      check("done",  k, int'(dd[k]), mdone[k] ? 1 : 0);
    end
  endtask

  task automatic clear_acc();
    for (int k = 0; k < 3; k++) begin
      acc[k].delete();
      nlast[k] = 0;
      ndone[k] = 0;
      nbusy[k] = 0;
    end
  endtask

  // Inputs are already set on entry; record what the sink sees, clock once,
  // advance the model, then compare on the falling edge.
  task automatic cyc();
    for (int k = 0; k < 3; k++) begin
      if (rst_n && en && dv[k] && out_ready) begin
        acc[k].push_back(int'(dq[k]));
        if (dl[k]) nlast[k]++;
      end
      if (dd[k]) ndone[k]++;
      if (db[k]) nbusy[k]++;
    end
    @(posedge clk50m);
    model_step();
    @(negedge clk50m);
    compare_all();
  endtask

  task automatic chk_stream(string nm, int k, logic [15:0] exp, int cnt);
    logic [15:0] recon;
    recon = '0;
    foreach (acc[k][i]) recon = (recon << BK[k]) | 16'(acc[k][i]);
    check({nm, "_count"}, k, acc[k].size(), cnt);
    check(nm, k, int'(recon), int'(exp));
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    model_clear();
    compare_all();
    check("rst_data", 0, int'(dq[0]), 0);
    check("rst_busy", 0, int'(db[0]), 0);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; rd_req = 1'b0; out_ready = 1'b0;
    rd16 = '0; rd8 = '0;
    model_clear();
    clear_acc();
    repeat (2) @(negedge clk50m);
    compare_all();
    check("reset_valid", 0, int'(v0), 0);
    check("reset_done", 0, int'(d0), 0);
    rst_n = 1'b1;

    check("pin_chunk", 0, chunk_of(0, 16'hA5C3, 2), 12);
    check("pin_bit", 2, chunk_of(2, 16'hA5C3, 15), 1);

    // Plain stream on all three shapes
    clear_acc();
    en = 1'b1; out_ready = 1'b1; rd16 = 16'hA5C3; rd8 = 8'h5A;
    rd_req = 1'b1; cyc(); rd_req = 1'b0;
    repeat (20) cyc();
    chk_stream("s1_stream", 0, 16'hA5C3, 4);
    chk_stream("s1_stream", 1, 16'h005A, 1);
    chk_stream("s1_stream", 2, 16'hA5C3, 16);
    check("s1_busy", 0, nbusy[0], 5);
    check("s1_busy", 1, nbusy[1], 2);
    check("s1_busy", 2, nbusy[2], 17);
    for (int k = 0; k < 3; k++) begin
      check("s1_done", k, ndone[k], 1);
      check("s1_last", k, nlast[k], 1);
    end

    // Backpressure pattern
    clear_acc();
    rd_req = 1'b1; cyc(); rd_req = 1'b0;
    begin
      bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 7; i++) begin
        out_ready = pat[i];
        cyc();
      end
    end
    check("s2_done_now", 0, int'(d0), 1);
    out_ready = 1'b1;
    repeat (20) cyc();
    chk_stream("s2_stream", 0, 16'hA5C3, 4);
    check("s2_done", 0, ndone[0], 1);

    // Capture isolation and ignored request during SEND
    clear_acc();
    rd16 = 16'h1234; rd_req = 1'b1; cyc();
    rd16 = 16'hFFFF; rd_req = 1'b0; cyc();
    rd_req = 1'b1; cyc();
    rd_req = 1'b0;
    repeat (25) cyc();
    chk_stream("s3_stream", 0, 16'h1234, 4);
    chk_stream("s3_stream", 2, 16'h1234, 16);

    // Freeze mid-stream
    clear_acc();
    rd16 = 16'hA5C3; rd_req = 1'b1; cyc(); rd_req = 1'b0;
    cyc(); cyc();
    en = 1'b0;
    repeat (3) begin
      cyc();
      check("s4_hold", 0, int'(o0), 4'hC);
    end
    en = 1'b1;
    repeat (20) cyc();
    chk_stream("s4_stream", 0, 16'hA5C3, 4);

    // Reset mid-word, then a clean word
    rd16 = 16'hBEEF; rd_req = 1'b1; cyc(); rd_req = 1'b0;
    cyc();
    check("s5_pre", 0, int'(o0), 4'hE);
    reset_pulse();
    clear_acc();
    rd16 = 16'h0F0F; rd_req = 1'b1; cyc(); rd_req = 1'b0;
    repeat (20) cyc();
    chk_stream("s5_stream", 0, 16'h0F0F, 4);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      en        = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rd_req    = ($urandom_range(0, 3) == 0);
      rd16      = 16'($urandom);
      rd8       = 8'($urandom);
      if ($urandom_range(0, 299) == 0) reset_pulse();
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
